cc_column_tracker: RTL and testbench

Observer for one cc player column: samples the N `light` outputs of the column's cc light cells on the same 2^WIDTH-cycle step cadence the cells use. Per step it encodes the lit position and checks that exactly one light is lit. It detects the top-of-column win condition and drives the column's shared `over` line back into every cell. It sits between the light column and the game-level controller / display logic.

---
 rtl/cc_pkg.sv | 14 +
 rtl/cc_onehot_enc.sv | 23 ++
 rtl/cc_column_tracker.sv | 120 ++++++++++++
 tb/tb_cc_column_tracker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cc_pkg.sv
// Shared types and widths for the cc column tracker.
package cc_pkg;

    localparam int unsigned CC_SCORE_W = 8;
    localparam int unsigned CC_HOLD_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        TOP,
        OVER
    } cc_trk_state_t;

endpackage

// File: rtl/cc_onehot_enc.sv
// Combinational one-hot to binary encoder with a one-hot validity flag.
module cc_onehot_enc #(
    parameter int unsigned N  = 8,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          onehot
);

    // OR of all set-bit indices; exact only when vec is one-hot
    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = idx | IW'(i);
            end
        end
    end

    assign onehot = (vec != '0) && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/cc_column_tracker.sv
// Column observer: step-aligned sampling, position encoding, win detection.
// Optional step score counter enabled by CC_TRACKER_SCORE_EN.
module cc_column_tracker
    import cc_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned WIDTH = 7,
    parameter int unsigned HOLD  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  active,
    input  logic [N-1:0]          lights,
    output logic [$clog2(N)-1:0]  pos,
    output logic                  pos_valid,
    output logic                  over,
    output logic                  err,
    output logic                  step
`ifdef CC_TRACKER_SCORE_EN
    ,
    output logic [CC_SCORE_W-1:0] score
`endif
);

    localparam int unsigned PW = $clog2(N);

    logic [WIDTH-1:0]     cnt;
    logic [PW-1:0]        idx_c;
    logic                 onehot_c;
    logic                 top_hit_c;
    logic [CC_HOLD_W-1:0] hold;
    logic [CC_HOLD_W-1:0] hold_inc_c;
    cc_trk_state_t        state;

    cc_onehot_enc #(
        .N  (N),
        .IW (PW)
    ) u_enc (
        .vec    (lights),
        .idx    (idx_c),
        .onehot (onehot_c)
    );

    assign top_hit_c  = onehot_c && lights[N-1];
    assign hold_inc_c = (hold == '1) ? hold : hold + CC_HOLD_W'(1);

    // Step counter kept in phase with the cells' counters
    always_ff @(posedge clk) begin
        if (reset || !active) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WIDTH'(1);
        end
    end

    // step is registered so it is high exactly while cnt == 1
    always_ff @(posedge clk) begin
        if (reset || !active) begin
            state     <= IDLE;
            hold      <= '0;
            pos       <= '0;
            pos_valid <= 1'b0;
            over      <= 1'b0;
            err       <= 1'b0;
            step      <= 1'b0;
`ifdef CC_TRACKER_SCORE_EN
            score     <= '0;
`endif
        end else begin
            step <= (cnt == '0);

            if (step) begin
                pos_valid <= onehot_c;
                if (onehot_c) begin
                    pos <= idx_c;
                end else begin
                    err <= 1'b1;
                end
`ifdef CC_TRACKER_SCORE_EN
                if ((state == PLAY || state == TOP) && onehot_c &&
                    idx_c >= PW'(N / 2) && score != '1) begin
                    score <= score + CC_SCORE_W'(1);
                end
`endif
            end

            case (state)
                IDLE: state <= PLAY;
                PLAY: begin
                    if (step && top_hit_c) begin
                        hold <= CC_HOLD_W'(1);
                        if (HOLD == 1) begin
                            state <= OVER;
                            over  <= 1'b1;
                        end else begin
                            state <= TOP;
                        end
                    end
                end
                TOP: begin
                    if (step) begin
                        if (top_hit_c) begin
                            hold <= hold_inc_c;
                            if (hold_inc_c == CC_HOLD_W'(HOLD)) begin
                                state <= OVER;
                                over  <= 1'b1;
                            end
                        end else begin
                            hold  <= '0;
                            state <= PLAY;
                        end
                    end
                end
                OVER: over <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cc_column_tracker.sv
// Directed self-checking bench for cc_column_tracker (N=8, WIDTH=2, HOLD=3).
module tb_cc_column_tracker;

    logic       clk;
    logic       reset;
    logic       active;
    logic [7:0] lights;
    logic [2:0] pos;
    logic       pos_valid;
    logic       over;
    logic       err;
    logic       step;
`ifdef CC_TRACKER_SCORE_EN
    logic [7:0] score;
`endif

    int checks   = 0;
    int failures = 0;

    cc_column_tracker #(
        .N     (8),
        .WIDTH (2),
        .HOLD  (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .active    (active),
        .lights    (lights),
        .pos       (pos),
        .pos_valid (pos_valid),
        .over      (over),
        .err       (err),
        .step      (step)
`ifdef CC_TRACKER_SCORE_EN
        ,
        .score     (score)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Wait for a step strobe, then one more cycle so outputs reflect that step
    task automatic do_step();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!step && n < 16);
        check("step_seen", int'(step), 1);
        @(negedge clk);
    endtask

    task automatic abort_cycle();
        active = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pos"}, int'(pos), 0);
        check({tag, "_valid"}, int'(pos_valid), 0);
        check({tag, "_over"}, int'(over), 0);
        check({tag, "_err"}, int'(err), 0);
        check({tag, "_step"}, int'(step), 0);
`ifdef CC_TRACKER_SCORE_EN
        check({tag, "_score"}, int'(score), 0);
`endif
    endtask

    initial begin
        int gap;
        reset  = 1'b1;
        active = 1'b1;
        lights = 8'h01;

        // Reset held for 3 cycles with active high: step must never pulse
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_step", int'(step), 0);
        end
        check_all_zero("rst");

        // Encoding
        reset  = 1'b0;
        lights = 8'h04;
        do_step();
        check("enc_pos", int'(pos), 2);
        check("enc_valid", int'(pos_valid), 1);
        check("enc_over", int'(over), 0);
        check("enc_strobe_len", int'(step), 0);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!step && gap < 16);
        check("enc_step_gap", gap, 3);
        @(negedge clk);
        check("enc_pos2", int'(pos), 2);
`ifdef CC_TRACKER_SCORE_EN
        check("enc_score", int'(score), 0);
`endif

        // Win: top light for three steps
        lights = 8'h80;
        do_step();
        check("win_over1", int'(over), 0);
        check("win_pos", int'(pos), 7);
        do_step();
        check("win_over2", int'(over), 0);
        do_step();
        check("win_over3", int'(over), 1);
        do_step();
        check("win_over_hold", int'(over), 1);
        check("win_err", int'(err), 0);
`ifdef CC_TRACKER_SCORE_EN
        check("win_score_frozen", int'(score), 3);
`endif

        // Interrupted top
        abort_cycle();
        check_all_zero("abort1");
        active = 1'b1;
        lights = 8'h80;
        do_step();
        do_step();
        lights = 8'h40;
        do_step();
        check("int_pos6", int'(pos), 6);
        lights = 8'h80;
        do_step();
        do_step();
        check("int_over", int'(over), 0);
        check("int_pos7", int'(pos), 7);
        check("int_err", int'(err), 0);
`ifdef CC_TRACKER_SCORE_EN
        check("int_score", int'(score), 5);
`endif

        // Error: empty sample then valid sample
        abort_cycle();
        active = 1'b1;
        lights = 8'h00;
        do_step();
        check("err_valid0", int'(pos_valid), 0);
        check("err_set", int'(err), 1);
        check("err_pos_hold", int'(pos), 0);
        lights = 8'h10;
        do_step();
        check("err_valid1", int'(pos_valid), 1);
        check("err_pos4", int'(pos), 4);
        check("err_sticky", int'(err), 1);
        lights = 8'h18;
        do_step();
        check("err_multi_valid", int'(pos_valid), 0);
        check("err_multi_pos", int'(pos), 4);

        // Abort from TOP with hold=2, then a full three steps to win
        abort_cycle();
        active = 1'b1;
        lights = 8'h80;
        do_step();
        do_step();
        check("ab_over_pre", int'(over), 0);
        abort_cycle();
        check_all_zero("abort2");
        active = 1'b1;
        do_step();
        do_step();
        check("ab_over_2steps", int'(over), 0);
        do_step();
        check("ab_over_3steps", int'(over), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
